// File: rtl/dsm_cic_decimator.sv
// rtl/dsm_cic_decimator.sv - 3-level DSM symbol demodulator with sinc^3 CIC decimation
// Maps pwm codes to {-1,0,+1}, integrates at input rate, combs at output rate R=2^LOG2_DEC.
module dsm_cic_decimator #(
    parameter  int LOG2_DEC = 6,
    localparam int W        = 2 + 3 * LOG2_DEC
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         en,
    input  logic [1:0]   pwm,
    input  logic         err_clr,
    output logic [W-1:0] dout,
    output logic         dout_valid,
    output logic         err
);

    logic [W-1:0]        i1_q, i2_q, i3_q, i1_d, i2_d, i3_d;
    logic [W-1:0]        d1_q, d2_q, d3_q, d1_d, d2_d, d3_d;
    logic [W-1:0]        dout_q, dout_d;
    logic                valid_q, valid_d;
    logic                err_q, err_d;
    logic [LOG2_DEC-1:0] cnt_q, cnt_d;
    logic [W-1:0]        x, c1, c2, c3;
    logic                strobe;

    always_comb begin
        x = '0;
        case (pwm)
            2'b01:   x = W'(1);
            2'b11:   x = '1;
            default: x = '0;
        endcase
    end

    // Comb stage uses the registered i3, i.e. the value before this strobe edge.
    assign strobe = en && (cnt_q == '1);
    assign c1     = i3_q - d1_q;
    assign c2     = c1 - d2_q;
    assign c3     = c2 - d3_q;

    always_comb begin
        i1_d    = i1_q;
        i2_d    = i2_q;
        i3_d    = i3_q;
        d1_d    = d1_q;
        d2_d    = d2_q;
        d3_d    = d3_q;
        dout_d  = dout_q;
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        if (en) begin
            i1_d  = i1_q + x;
            i2_d  = i2_q + i1_q;
            i3_d  = i3_q + i2_q;
            cnt_d = cnt_q + 1'b1;
            if (strobe) begin
                d1_d    = i3_q;
                d2_d    = c1;
                d3_d    = c2;
                dout_d  = c3;
                valid_d = 1'b1;
            end
        end
        // A new illegal symbol takes priority over a simultaneous clear.
        if (en && pwm == 2'b10) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            i1_q    <= '0;
            i2_q    <= '0;
            i3_q    <= '0;
            d1_q    <= '0;
            d2_q    <= '0;
            d3_q    <= '0;
            dout_q  <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            i1_q    <= i1_d;
            i2_q    <= i2_d;
            i3_q    <= i3_d;
            d1_q    <= d1_d;
            d2_q    <= d2_d;
            d3_q    <= d3_d;
            dout_q  <= dout_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = valid_q;
    assign err        = err_q;

endmodule

// File: tb/tb_dsm_cic_decimator.sv
// tb/tb_dsm_cic_decimator.sv - scoreboard bench for dsm_cic_decimator
module tb_dsm_cic_decimator;

    localparam int LOG2_DEC = 6;
    localparam int W        = 2 + 3 * LOG2_DEC;
    localparam int R        = 1 << LOG2_DEC;
    localparam int GAIN     = R * R * R;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         en = 1'b0;
    logic [1:0]   pwm = 2'b00;
    logic         err_clr = 1'b0;
    logic [W-1:0] dout;
    logic         dout_valid;
    logic         err;

    typedef struct {
        time t;
        bit  chk;
        int  val;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   acc_cnt = 0;
    int   pulse_no = 0;
    int   chk_from = 5;
    int   exp_val = 0;

    dsm_cic_decimator #(.LOG2_DEC(LOG2_DEC)) dut (
        .clock      (clock),
        .reset      (reset),
        .en         (en),
        .pwm        (pwm),
        .err_clr    (err_clr),
        .dout       (dout),
        .dout_valid (dout_valid),
        .err        (err)
    );

    always #5 clock = ~clock;

    // Drive one cycle; every R-th accepted symbol schedules a pulse at the next negedge.
    task automatic drive_sym(input logic e, input logic [1:0] p);
        en  = e;
        pwm = p;
        @(posedge clock);
        if (e) begin
            acc_cnt++;
            if (acc_cnt % R == 0) begin
                pulse_no = acc_cnt / R;
                sb.push_back('{t: $time + 5, chk: (pulse_no >= chk_from), val: exp_val});
            end
        end
        #1;
    endtask

    task automatic do_reset();
        #2 reset = 1'b1;
        sb.delete();
        acc_cnt  = 0;
        pulse_no = 0;
        en       = 1'b0;
        pwm      = 2'b00;
        err_clr  = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    always @(negedge clock) begin
        if (dout_valid) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_valid t=%0t dout=%0d required=no pulse", $time, $signed(dout));
            end else begin
                exp_t e;
                e = sb.pop_front();
                if ($time != e.t) begin
                    miscompares++;
                    $display("FAIL valid_timing got t=%0t required t=%0t", $time, e.t);
                end else if (e.chk && $signed(dout) !== e.val) begin
                    miscompares++;
                    $display("FAIL dout pulse=%0d got %0d required %0d", vectors, $signed(dout), e.val);
                end
            end
        end
    end

    task automatic test_reset();
        do_reset();
        #2 reset = 1'b1;
        #1;
        vectors += 3;
        if (dout !== '0) begin miscompares++; $display("FAIL reset_dout got %0d required 0", dout); end
        if (dout_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b required 0", dout_valid); end
        if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err got %b required 0", err); end
        @(posedge clock);
        #1 reset = 1'b0;
    endtask

    task automatic test_const_pos();
        do_reset();
        chk_from = 5;
        exp_val  = GAIN;
        for (int i = 0; i < 10 * R; i++) drive_sym(1'b1, 2'b01);
        @(negedge clock); #1;
        vectors++;
        if (sb.size() != 0) begin miscompares++; $display("FAIL const_pos_missing got %0d pending required 0", sb.size()); end
    endtask

    task automatic test_const_neg_then_zero();
        int sw;
        do_reset();
        chk_from = 5;
        exp_val  = -GAIN;
        for (int i = 0; i < 10 * R; i++) drive_sym(1'b1, 2'b11);
        sw       = pulse_no;
        chk_from = sw + 4;
        exp_val  = 0;
        for (int i = 0; i < 8 * R; i++) drive_sym(1'b1, 2'b00);
        @(negedge clock); #1;
        vectors++;
        if (sb.size() != 0) begin miscompares++; $display("FAIL neg_zero_missing got %0d pending required 0", sb.size()); end
    endtask

    task automatic test_alternating();
        do_reset();
        chk_from = 5;
        exp_val  = 0;
        for (int i = 0; i < 10 * R; i++) drive_sym(1'b1, (i % 2 == 0) ? 2'b01 : 2'b11);
        @(negedge clock); #1;
        vectors++;
        if (sb.size() != 0) begin miscompares++; $display("FAIL alt_missing got %0d pending required 0", sb.size()); end
    endtask

    task automatic test_en_gaps();
        int guard;
        do_reset();
        chk_from = 5;
        exp_val  = GAIN;
        guard    = 0;
        while (acc_cnt < 10 * R && guard < 20 * R) begin
            if ($urandom_range(0, 1) == 1) drive_sym(1'b1, 2'b01);
            else drive_sym(1'b0, 2'($urandom_range(0, 3)));
            guard++;
        end
        @(negedge clock); #1;
        vectors += 3;
        if (acc_cnt != 10 * R) begin miscompares++; $display("FAIL gaps_budget got %0d accepted required %0d", acc_cnt, 10 * R); end
        if (sb.size() != 0) begin miscompares++; $display("FAIL gaps_missing got %0d pending required 0", sb.size()); end
        if (err !== 1'b0) begin miscompares++; $display("FAIL gaps_err_gated got %b required 0", err); end
    endtask

    task automatic test_err();
        chk_from = 1 << 30;
        drive_sym(1'b1, 2'b01);
        drive_sym(1'b0, 2'b10);
        vectors++;
        if (err !== 1'b0) begin miscompares++; $display("FAIL err_idle_code got %b required 0", err); end
        drive_sym(1'b1, 2'b10);
        vectors++;
        if (err !== 1'b1) begin miscompares++; $display("FAIL err_set got %b required 1", err); end
        for (int i = 0; i < 5; i++) drive_sym(1'b1, 2'b00);
        vectors++;
        if (err !== 1'b1) begin miscompares++; $display("FAIL err_sticky got %b required 1", err); end
        err_clr = 1'b1;
        drive_sym(1'b1, 2'b01);
        err_clr = 1'b0;
        vectors++;
        if (err !== 1'b0) begin miscompares++; $display("FAIL err_clear got %b required 0", err); end
        drive_sym(1'b1, 2'b00);
        vectors++;
        if (err !== 1'b0) begin miscompares++; $display("FAIL err_stays_clear got %b required 0", err); end
        err_clr = 1'b1;
        drive_sym(1'b1, 2'b10);
        err_clr = 1'b0;
        vectors++;
        if (err !== 1'b1) begin miscompares++; $display("FAIL err_set_wins got %b required 1", err); end
    endtask

    task automatic test_async_reset_midframe();
        do_reset();
        chk_from = 1 << 30;
        for (int i = 0; i < 2 * R; i++) drive_sym(1'b1, 2'b01);
        drive_sym(1'b1, 2'b10);
        while (acc_cnt % R != 30) drive_sym(1'b1, 2'b01);
        vectors += 2;
        if (dout === '0) begin miscompares++; $display("FAIL pre_reset_dout got 0 required nonzero"); end
        if (err !== 1'b1) begin miscompares++; $display("FAIL pre_reset_err got %b required 1", err); end
        #1 reset = 1'b1;
        #1;
        vectors += 3;
        if (dout !== '0) begin miscompares++; $display("FAIL async_dout got %0d required 0", dout); end
        if (dout_valid !== 1'b0) begin miscompares++; $display("FAIL async_valid got %b required 0", dout_valid); end
        if (err !== 1'b0) begin miscompares++; $display("FAIL async_err got %b required 0", err); end
        sb.delete();
        acc_cnt  = 0;
        pulse_no = 0;
        chk_from = 1;
        exp_val  = 0;
        @(posedge clock);
        #1 reset = 1'b0;
        for (int i = 0; i < R; i++) drive_sym(1'b1, 2'b00);
        for (int i = 0; i < 3; i++) drive_sym(1'b0, 2'b00);
        vectors++;
        if (sb.size() != 0) begin miscompares++; $display("FAIL post_reset_pulse got %0d pending required 0", sb.size()); end
    endtask

    initial begin
        test_reset();
        test_const_pos();
        test_const_neg_then_zero();
        test_alternating();
        test_en_gaps();
        test_err();
        test_async_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
